// File: rtl/perceptron_pkg.sv
// Shared types for the perceptron controller and datapath: FSM state encoding and
// the W1W0b shift-select codes the datapath decodes.
package perceptron_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_W1 = 3'd1,
    S_LOAD_W0 = 3'd2,
    S_LOAD_B  = 3'd3,
    S_READY   = 3'd4,
    S_EGRESS  = 3'd5,
    S_OUTPUT  = 3'd6
  } state_t;

  localparam logic [1:0] SEL_W1   = 2'b11;
  localparam logic [1:0] SEL_W0   = 2'b10;
  localparam logic [1:0] SEL_B    = 2'b01;
  localparam logic [1:0] SEL_NONE = 2'b00;

endpackage

// File: rtl/perceptron_ctrl.sv
// Perceptron sequencer: serialises W1/W0/b MSB-first into the datapath, then runs
// inferences at one result per 2 cycles. Define PERCEPTRON_CTRL_STATS_EN for infer_cnt_o.
module perceptron_ctrl
  import perceptron_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cfg_valid_i,
  output logic                 cfg_ready_o,
  input  logic [WIDTH-1:0]     cfg_w0_i,
  input  logic [WIDTH-1:0]     cfg_w1_i,
  input  logic [WIDTH-1:0]     cfg_b_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [1:0]           W1W0b_en_o,
  output logic                 W1_o,
  output logic                 W0_o,
  output logic                 b_o,
  output logic                 en_ingress_o,
  output logic                 en_egress_o,
  output logic                 busy_o,
  output logic [CNT_WIDTH-1:0] infer_cnt_o
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] BIT_MSB = BW'(WIDTH - 1);

  state_t           r_state;
  logic [BW-1:0]    r_bit;
  logic [WIDTH-1:0] r_w1;
  logic [WIDTH-1:0] r_w0;
  logic [WIDTH-1:0] r_b;

  logic w_cfg_rdy;
  logic w_cfg_hs;
  logic w_in_rdy;
  logic w_out_hs;

  // A pending cfg in READY blocks the X pair so a reload always wins.
  assign w_cfg_rdy = (r_state == S_IDLE) || (r_state == S_READY);
  assign w_cfg_hs  = cfg_valid_i && w_cfg_rdy;
  assign w_in_rdy  = ((r_state == S_READY) && !cfg_valid_i) ||
                     ((r_state == S_OUTPUT) && out_ready_i);
  assign w_out_hs  = (r_state == S_OUTPUT) && out_ready_i;

  assign cfg_ready_o  = w_cfg_rdy;
  assign in_ready_o   = w_in_rdy;
  assign en_ingress_o = w_in_rdy && in_valid_i;
  assign en_egress_o  = (r_state == S_EGRESS);
  assign out_valid_o  = (r_state == S_OUTPUT);
  assign busy_o       = (r_state == S_LOAD_W1) || (r_state == S_LOAD_W0) ||
                        (r_state == S_LOAD_B);

  always_comb begin
    W1W0b_en_o = SEL_NONE;
    case (r_state)
      S_LOAD_W1: W1W0b_en_o = SEL_W1;
      S_LOAD_W0: W1W0b_en_o = SEL_W0;
      S_LOAD_B:  W1W0b_en_o = SEL_B;
      default:   W1W0b_en_o = SEL_NONE;
    endcase
  end

  assign W1_o = (r_state == S_LOAD_W1) && r_w1[r_bit];
  assign W0_o = (r_state == S_LOAD_W0) && r_w0[r_bit];
  assign b_o  = (r_state == S_LOAD_B)  && r_b[r_bit];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_bit   <= '0;
      r_w1    <= '0;
      r_w0    <= '0;
      r_b     <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_READY: begin
          if (w_cfg_hs) begin
            r_w1    <= cfg_w1_i;
            r_w0    <= cfg_w0_i;
            r_b     <= cfg_b_i;
            r_bit   <= BIT_MSB;
            r_state <= S_LOAD_W1;
          end else if (r_state == S_READY && in_valid_i) begin
            r_state <= S_EGRESS;
          end
        end
        S_LOAD_W1, S_LOAD_W0, S_LOAD_B: begin
          if (r_bit == '0) begin
            r_bit   <= BIT_MSB;
            r_state <= (r_state == S_LOAD_W1) ? S_LOAD_W0 :
                       (r_state == S_LOAD_W0) ? S_LOAD_B  : S_READY;
          end else begin
            r_bit <= r_bit - BW'(1);
          end
        end
        S_EGRESS: r_state <= S_OUTPUT;
        S_OUTPUT: begin
          if (out_ready_i) r_state <= in_valid_i ? S_EGRESS : S_READY;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef PERCEPTRON_CTRL_STATS_EN
  logic [CNT_WIDTH-1:0] r_infer_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      r_infer_cnt <= '0;
    else if (w_out_hs) r_infer_cnt <= r_infer_cnt + CNT_WIDTH'(1);
  end

  assign infer_cnt_o = r_infer_cnt;
`else
  assign infer_cnt_o = '0;
`endif

endmodule
